// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-port round-robin arbiter in front of a single-port, fixed-latency memory.
// The instruction-fetch (IF) and load/store (DM) ports each raise a request
// level. One transaction is in flight at a time. The winner is issued to the
// memory, the fixed read latency is counted down, and a one-cycle done pulse
// with captured read data is returned to the port that owns the transaction.
//
// state | meaning
// IDLE  | sample if_req/dm_req, issue the winner on this edge
// WAIT  | count memory latency down from MEM_LAT
// RESP  | mem_rdata valid; capture it (reads) and pulse done at the closing edge

module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic              if_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_wdata,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Counter reload; MEM_LAT is limited to 1..15 so it fits the 4-bit counter.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       prio_dm;   // 1: DM wins the next tie
  logic       owner_dm;  // 1: outstanding transaction belongs to DM
  logic       issue;
  logic       pick_dm;

  // Winner selection in IDLE: a lone requester wins, a tie goes to prio_dm.
  always_comb begin
    issue   = 1'b0;
    pick_dm = 1'b0;
    if (state == ST_IDLE) begin
      issue   = if_req | dm_req;
      pick_dm = dm_req & (~if_req | prio_dm);
    end
  end

  // Sequencing FSM: latency countdown, ownership and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      owner_dm <= 1'b0;
      prio_dm  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state    <= ST_WAIT;
            cnt      <= LAT_LOAD;
            busy     <= 1'b1;
            owner_dm <= pick_dm;
            prio_dm  <= ~pick_dm;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory-side port: single-cycle strobe, attributes held until done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= issue;
      if (issue) begin
        mem_we    <= pick_dm ? dm_we    : if_we;
        mem_addr  <= pick_dm ? dm_addr  : if_addr;
        mem_wdata <= pick_dm ? dm_wdata : if_wdata;
      end else if (state == ST_RESP) begin
        mem_we <= 1'b0;
      end
    end
  end

  // Grant pulses, one cycle, in the issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
    end else begin
      if_gnt <= issue & ~pick_dm;
      dm_gnt <= issue & pick_dm;
    end
  end

  // Completion: done pulse to the owner and read-data capture for reads only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= (state == ST_RESP) & ~owner_dm;
      dm_done <= (state == ST_RESP) & owner_dm;
      if ((state == ST_RESP) && !mem_we) begin
        if (owner_dm) begin
          dm_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A negedge monitor pops expected
// transactions from a scoreboard queue on every grant and checks the issue,
// hold, done timing and returned data. A second instance with MEM_LAT=1
// covers back-to-back reads.

module tb_mem_port_arbiter;

  localparam int LAT_A = 2;

  typedef struct {
    logic        dm;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  // DUT A (MEM_LAT = 2)
  logic        if_req, if_we, dm_req, dm_we;
  logic [63:0] if_addr, if_wdata, dm_addr, dm_wdata;
  logic        if_gnt, if_done, dm_gnt, dm_done;
  logic [63:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  // DUT B (MEM_LAT = 1)
  logic        if_req_b;
  logic [63:0] if_addr_b;
  logic        if_gnt_b, if_done_b, dm_gnt_b, dm_done_b;
  logic [63:0] if_rdata_b, dm_rdata_b;
  logic        mem_en_b, mem_we_b, busy_b;
  logic [63:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [63:0] zero64;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_we(1'b0), .if_addr(if_addr_b), .if_wdata(zero64),
    .if_gnt(if_gnt_b), .if_done(if_done_b), .if_rdata(if_rdata_b),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(zero64), .dm_wdata(zero64),
    .dm_gnt(dm_gnt_b), .dm_done(dm_done_b), .dm_rdata(dm_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: explicit writes, else an address-derived pattern.
  logic [63:0] bmem [logic [63:0]];

  function automatic logic [63:0] mem_lookup(input logic [63:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
  endfunction

  // Memory pipelines: data valid exactly MEM_LAT cycles after mem_en, junk otherwise.
  logic [63:0] pipe_a [LAT_A];
  logic [63:0] pipe_b;
  always @(posedge clk) begin
    pipe_a[0] <= mem_en ? mem_lookup(mem_addr) : {32'hBAD0_BAD0, 32'(cyc)};
    for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
    pipe_b    <= mem_en_b ? mem_lookup(mem_addr_b) : {32'hBAD1_BAD1, 32'(cyc)};
  end
  assign mem_rdata   = pipe_a[LAT_A-1];
  assign mem_rdata_b = pipe_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {57'd0, if_gnt, dm_gnt, if_done, dm_done, mem_en, mem_we, busy}, 64'd0);
    chk({tag, "_if_rdata"}, if_rdata, 64'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  // Scoreboard
  txn_t        exp_q[$];
  txn_t        pend;
  logic        pend_v;
  int          pend_issue;
  logic [63:0] pend_rd;
  logic [63:0] m_if_rd, m_dm_rd;

  task automatic push(input logic dm, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata);
    txn_t t;
    t.dm = dm; t.we = we; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  initial begin
    pend_v = 1'b0;
    pend_issue = 0;
    m_if_rd = '0;
    m_dm_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_zero("mon_rst");
        pend_v  = 1'b0;
        m_if_rd = '0;
        m_dm_rd = '0;
      end else begin
        if (mem_en && mem_we) bmem[mem_addr] = mem_wdata;
        if (if_gnt || dm_gnt) begin
          chk("gnt_onehot", {63'd0, if_gnt & dm_gnt}, 64'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_gnt", 64'd1, 64'd0);
          end else begin
            txn_t it;
            it = exp_q.pop_front();
            chk("gnt_port_dm", {63'd0, dm_gnt}, {63'd0, it.dm});
            chk("issue_mem_en", {63'd0, mem_en}, 64'd1);
            chk("issue_mem_addr", mem_addr, it.addr);
            chk("issue_mem_we", {63'd0, mem_we}, {63'd0, it.we});
            if (it.we) chk("issue_mem_wdata", mem_wdata, it.wdata);
            pend = it;
            pend_v = 1'b1;
            pend_issue = cyc;
            pend_rd = it.we ? (it.dm ? m_dm_rd : m_if_rd) : mem_lookup(it.addr);
          end
        end else begin
          chk("mem_en_low", {63'd0, mem_en}, 64'd0);
          if (pend_v) begin
            chk("hold_mem_addr", mem_addr, pend.addr);
            if (pend.we) chk("hold_mem_wdata", mem_wdata, pend.wdata);
          end
        end
        if (if_done || dm_done) begin
          if (!pend_v) begin
            chk("spurious_done", 64'd1, 64'd0);
          end else begin
            chk("done_cycle", 64'(cyc), 64'(pend_issue + LAT_A + 1));
            chk("done_port_dm", {63'd0, dm_done}, {63'd0, pend.dm});
            if (pend.dm) m_dm_rd = pend_rd; else m_if_rd = pend_rd;
            pend_v = 1'b0;
          end
        end else if (pend_v && cyc > pend_issue + LAT_A + 1) begin
          chk("done_timeout", 64'd1, 64'd0);
          pend_v = 1'b0;
        end
        chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
        chk("busy", {63'd0, busy}, {63'd0, pend_v});
        if (!pend_v && !(if_gnt || dm_gnt)) chk("mem_we_idle", {63'd0, mem_we}, 64'd0);
      end
    end
  end

  task automatic wait_gnt(input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("gnt_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done(input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (if_done || dm_done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("done_timeout_wait", 64'd1, 64'd0);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_we = 0; if_addr = '0; if_wdata = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
  endtask

  int e, d, prev;
  logic [63:0] exp_b;

  initial begin
    checks = 0; errors = 0; cyc = 0; zero64 = '0;
    if_req_b = 0; if_addr_b = '0;
    idle_inputs();
    rst = 1'b1;
    bmem[64'h40] = 64'h0000_0000_00A0_0093;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = 1'($urandom); dm_req = 1'($urandom);
      if_we = 1'($urandom);  dm_we = 1'($urandom);
      if_addr = {$urandom, $urandom}; dm_addr = {$urandom, $urandom};
      if_wdata = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
      #1 chk_zero("reset");
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_req_mem_en", {63'd0, mem_en}, 64'd0);
    end

    // Single IF read
    if_req = 1; if_addr = 64'h40; if_we = 0;
    push(1'b0, 1'b0, 64'h40, 64'd0);
    wait_gnt(10, e);
    chk("ifr_if_gnt", {63'd0, if_gnt}, 64'd1);
    if_req = 0;
    wait_done(10, d);
    chk("ifr_done_cycle", 64'(d), 64'(e + 3));
    chk("ifr_if_done", {63'd0, if_done}, 64'd1);
    chk("ifr_if_rdata", if_rdata, 64'h00A0_0093);
    chk("ifr_dm_quiet", {61'd0, dm_gnt, dm_done, 1'b0}, 64'd0);
    chk("ifr_dm_rdata", dm_rdata, 64'd0);

    // DM write, then read it back
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_addr = 64'h100; dm_wdata = 64'hDEAD_BEEF;
    push(1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF);
    wait_gnt(10, e);
    chk("dmw_mem_we", {63'd0, mem_we}, 64'd1);
    dm_req = 0; dm_we = 0; dm_wdata = '0;
    @(negedge clk);
    chk("dmw_en_single", {63'd0, mem_en}, 64'd0);
    chk("dmw_wdata_hold", mem_wdata, 64'hDEAD_BEEF);
    wait_done(10, d);
    chk("dmw_done_cycle", 64'(d), 64'(e + 3));
    chk("dmw_dm_rdata_unchanged", dm_rdata, 64'd0);
    dm_req = 1; dm_addr = 64'h100;
    push(1'b1, 1'b0, 64'h100, 64'd0);
    wait_gnt(10, e);
    dm_req = 0;
    wait_done(10, d);
    chk("dmr_readback", dm_rdata, 64'hDEAD_BEEF);

    // Contention from reset: DM, IF, DM, IF, issues 4 cycles apart
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    if_req = 1; if_addr = 64'h0; dm_req = 1; dm_addr = 64'h100;
    push(1'b1, 1'b0, 64'h100, 64'd0);
    push(1'b0, 1'b0, 64'h0,   64'd0);
    push(1'b1, 1'b0, 64'h100, 64'd0);
    push(1'b0, 1'b0, 64'h0,   64'd0);
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(12, e);
      chk("cont_order_dm", {63'd0, dm_gnt}, (i % 2 == 0) ? 64'd1 : 64'd0);
      if (prev >= 0) chk("cont_spacing", 64'(e - prev), 64'd4);
      prev = e;
    end
    if_req = 0; dm_req = 0;
    wait_done(10, d);
    chk("cont_last_if_rdata", if_rdata, {32'hFFFF_FFFF, 32'h1357_9BDF});

    // Reset during WAIT drops the IF read
    @(negedge clk);
    if_req = 1; if_addr = 64'h80;
    push(1'b0, 1'b0, 64'h80, 64'd0);
    wait_gnt(10, e);
    if_req = 0;
    @(negedge clk);
    #2 rst = 1;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", {62'd0, if_done, dm_done}, 64'd0);
    end
    dm_req = 1; dm_addr = 64'h200;
    push(1'b1, 1'b0, 64'h200, 64'd0);
    wait_gnt(10, e);
    dm_req = 0;
    wait_done(10, d);
    chk("post_rst_dm_rdata", dm_rdata, {~32'h200, 32'h200 ^ 32'h1357_9BDF});
    chk("post_rst_q_empty", 64'(exp_q.size()), 64'd0);

    // MEM_LAT=1 back-to-back IF reads on the second instance
    @(negedge clk);
    if_req_b = 1; if_addr_b = 64'h1000;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      e = -1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (if_gnt_b) begin e = cyc; break; end
      end
      if (e < 0) chk("b_gnt_timeout", 64'd1, 64'd0);
      chk("b_mem_addr", mem_addr_b, 64'h1000 + 64'(i * 8));
      if (prev >= 0) chk("b_gnt_spacing", 64'(e - prev), 64'd3);
      prev = e;
      exp_b = mem_lookup(if_addr_b);
      if (i == 3) if_req_b = 0; else if_addr_b = 64'h1000 + 64'((i + 1) * 8);
      d = -1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (if_done_b) begin d = cyc; break; end
      end
      if (d < 0) chk("b_done_timeout", 64'd1, 64'd0);
      chk("b_done_latency", 64'(d - e), 64'd2);
      chk("b_if_rdata", if_rdata_b, exp_b);
    end
    repeat (4) @(negedge clk);
    chk("b_dm_quiet", {62'd0, dm_gnt_b, dm_done_b}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
